// File: rtl/regfile_pkg.sv
// Shared defines for the register file: bus widths, register count and the
// enable/reset polarity constants used by every file of the block.
package regfile_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int RegNum     = 32;
    localparam int RegNumLog2 = 5;

    localparam logic [RegBus-1:0]     ZeroWord    = '0;
    localparam logic [RegAddrBus-1:0] NOPRegAddr  = '0;
    localparam logic                  WriteEnable = 1'b1;
    localparam logic                  ReadEnable  = 1'b1;
    localparam logic                  RstEnable   = 1'b0;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: enable gating, $0 forcing, write-through bypass
// and the array value, in that priority order.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int REG_NUM_LOG2 = RegNumLog2
) (
    input  logic                    rst,
    input  logic                    re,
    input  logic [REG_NUM_LOG2-1:0] raddr,
    input  logic                    we,
    input  logic [REG_NUM_LOG2-1:0] waddr,
    input  logic [RegBus-1:0]       wdata,
    input  logic [RegBus-1:0]       arr_rdata,
    output logic [RegBus-1:0]       rdata
);

    always_comb begin
        rdata = ZeroWord;
        if (rst == RstEnable || re != ReadEnable || raddr == NOPRegAddr) begin
            rdata = ZeroWord;
        end else if (we == WriteEnable && waddr == raddr) begin
            // Same-cycle write is forwarded so the reader never sees a stale value.
            rdata = wdata;
        end else begin
            rdata = arr_rdata;
        end
    end

endmodule

// File: rtl/regfile.sv
// Two-read, one-write general-purpose register file with write-through bypass,
// a bypass-free debug read port and a committed-write counter.
module regfile
    import regfile_pkg::*;
#(
    parameter int REG_NUM      = RegNum,
    parameter int REG_NUM_LOG2 = RegNumLog2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [REG_NUM_LOG2-1:0] waddr,
    input  logic [RegBus-1:0]       wdata,
    input  logic                    re1,
    input  logic [REG_NUM_LOG2-1:0] raddr1,
    output logic [RegBus-1:0]       rdata1,
    input  logic                    re2,
    input  logic [REG_NUM_LOG2-1:0] raddr2,
    output logic [RegBus-1:0]       rdata2,
    input  logic [REG_NUM_LOG2-1:0] dbg_raddr,
    output logic [RegBus-1:0]       dbg_rdata,
    output logic [RegBus-1:0]       wr_count
);

    logic [RegBus-1:0] regs_q [REG_NUM];
    logic [RegBus-1:0] wr_count_q;
    logic [RegBus-1:0] wr_count_d;
    logic              wr_commit;

    always_comb begin
        wr_commit  = (we == WriteEnable) && (waddr != NOPRegAddr);
        wr_count_d = wr_commit ? wr_count_q + 1'b1 : wr_count_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= ZeroWord;
            end
            wr_count_q <= ZeroWord;
        end else begin
            if (wr_commit) begin
                regs_q[waddr] <= wdata;
            end
            wr_count_q <= wr_count_d;
        end
    end

    regfile_rdport #(.REG_NUM_LOG2(REG_NUM_LOG2)) u_rdport1 (
        .rst       (rst),
        .re        (re1),
        .raddr     (raddr1),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .arr_rdata (regs_q[raddr1]),
        .rdata     (rdata1)
    );

    regfile_rdport #(.REG_NUM_LOG2(REG_NUM_LOG2)) u_rdport2 (
        .rst       (rst),
        .re        (re2),
        .raddr     (raddr2),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .arr_rdata (regs_q[raddr2]),
        .rdata     (rdata2)
    );

    always_comb begin
        dbg_rdata = (rst == RstEnable) ? ZeroWord : regs_q[dbg_raddr];
    end

    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: a vector table for single-cycle behaviour plus
// hand-written sequences for reset, pending write and counter wrap.
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;
    logic [31:0] wr_count;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    regfile dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .re1       (re1),
        .raddr1    (raddr1),
        .rdata1    (rdata1),
        .re2       (re2),
        .raddr2    (raddr2),
        .rdata2    (rdata2),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata),
        .wr_count  (wr_count)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        re1;
        logic [4:0]  raddr1;
        logic        re2;
        logic [4:0]  raddr2;
        logic [4:0]  dbg;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] edbg;
        logic [31:0] ecnt;
    } vec_t;

    localparam int NV = 10;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic r1, input logic [4:0] a1,
                         input logic r2, input logic [4:0] a2, input logic [4:0] da);
        we = w; waddr = wa; wdata = wd;
        re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2; dbg_raddr = da;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);

        //              we waddr wdata          re1 a1     re2 a2     dbg    e1             e2             edbg           ecnt
        vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd1,  1'b0, 5'd5,  5'd5,  32'h0,         32'h0,         32'h0,         32'd0};
        vt[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b1, 5'd5,  5'd5,  32'hDEADBEEF,  32'hDEADBEEF,  32'hDEADBEEF,  32'd1};
        vt[2] = '{1'b1, 5'd7,  32'h12345678, 1'b1, 5'd7,  1'b1, 5'd7,  5'd7,  32'h12345678,  32'h12345678,  32'h0,         32'd1};
        vt[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  1'b1, 5'd7,  5'd7,  32'h0,         32'h12345678,  32'h12345678,  32'd2};
        vt[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b0, 5'd7,  5'd0,  32'h0,         32'h0,         32'h0,         32'd2};
        vt[5] = '{1'b1, 5'd5,  32'h11111111, 1'b1, 5'd5,  1'b1, 5'd7,  5'd5,  32'h11111111,  32'h12345678,  32'hDEADBEEF,  32'd2};
        vt[6] = '{1'b0, 5'd3,  32'hAAAAAAAA, 1'b1, 5'd3,  1'b1, 5'd5,  5'd3,  32'h0,         32'h11111111,  32'h0,         32'd3};
        vt[7] = '{1'b1, 5'd3,  32'hA5A5A5A5, 1'b1, 5'd5,  1'b1, 5'd3,  5'd31, 32'h11111111,  32'hA5A5A5A5,  32'h0,         32'd3};
        vt[8] = '{1'b1, 5'd31, 32'h00000001, 1'b1, 5'd3,  1'b1, 5'd31, 5'd3,  32'hA5A5A5A5,  32'h00000001,  32'hA5A5A5A5,  32'd4};
        vt[9] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b1, 5'd3,  5'd31, 32'h00000001,  32'hA5A5A5A5,  32'h00000001,  32'd5};

        // Outputs held at zero during reset even with a bypass candidate present.
        repeat (2) @(negedge clk);
        drive(1'b1, 5'd4, 32'hCAFEBABE, 1'b1, 5'd4, 1'b1, 5'd4, 5'd4);
        #1;
        chk("rst_rdata1_bypass", rdata1, 32'h0);
        chk("rst_rdata2_bypass", rdata2, 32'h0);
        chk("rst_wr_count", wr_count, 32'h0);

        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0);
        rst = 1'b1;
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(a); dbg_raddr = 5'(a);
            #1;
            chk($sformatf("post_rst_rd1_%0d", a), rdata1, 32'h0);
            chk($sformatf("post_rst_rd2_%0d", a), rdata2, 32'h0);
        end
        chk("post_rst_wr_count", wr_count, 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vt[i].we, vt[i].waddr, vt[i].wdata, vt[i].re1, vt[i].raddr1,
                  vt[i].re2, vt[i].raddr2, vt[i].dbg);
            #1;
            chk($sformatf("v%0d_rdata1", i), rdata1, vt[i].e1);
            chk($sformatf("v%0d_rdata2", i), rdata2, vt[i].e2);
            chk($sformatf("v%0d_dbg", i), dbg_rdata, vt[i].edbg);
            chk($sformatf("v%0d_wr_count", i), wr_count, vt[i].ecnt);
        end

        // Asynchronous reset between edges while a write to $3 is pending.
        @(negedge clk);
        drive(1'b1, 5'd3, 32'h5A5A5A5A, 1'b1, 5'd3, 1'b1, 5'd3, 5'd3);
        #2 rst = 1'b0;
        #1;
        chk("arst_wr_count_now", wr_count, 32'h0);
        chk("arst_rdata1_now", rdata1, 32'h0);
        chk("arst_rdata2_now", rdata2, 32'h0);
        dbg_raddr = 5'd5;
        #1;
        chk("arst_dbg5_now", dbg_rdata, 32'h0);
        @(negedge clk);
        we = 1'b0;
        rst = 1'b1;
        dbg_raddr = 5'd3;
        #1;
        chk("arst_rel_rdata1_r3", rdata1, 32'h0);
        chk("arst_rel_dbg_r3", dbg_rdata, 32'h0);
        chk("arst_rel_wr_count", wr_count, 32'h0);

        // A write pending at release commits on the first rising edge.
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        we = 1'b0;
        #1;
        chk("pend_dbg_r9", dbg_rdata, 32'hCAFEF00D);
        chk("pend_wr_count", wr_count, 32'd1);

        // Counter wrap from all-ones.
        @(negedge clk);
        force dut.wr_count_q = 32'hFFFFFFFF;
        #1;
        chk("wrap_preload", wr_count, 32'hFFFFFFFF);
        release dut.wr_count_q;
        drive(1'b1, 5'd10, 32'h00000001, 1'b0, 5'd0, 1'b0, 5'd0, 5'd10);
        @(negedge clk);
        we = 1'b0;
        #1;
        chk("wrap_wr_count", wr_count, 32'h0);
        chk("wrap_dbg_r10", dbg_rdata, 32'h00000001);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
